// File: rtl/softmax_normalizer.sv
// softmax_normalizer: last stage of the softmax datapath.
//   Buffers one row of exp() values (unsigned Q6.10) and accumulates their sum. It then takes
//   the reciprocal of the sum and streams every buffered element back out multiplied by that
//   reciprocal, in Q6.10.
//   FSM: StAccum (collect a row) -> StRecip (one cycle) -> StNorm (stream out) -> StAccum.
//
// Optional build macro: SOFTMAX_NORM_ROUND_EN
//   When defined, the output product is rounded half-up before the >>10.
//   When undefined, the product is truncated.
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_valid/i_data/    input element stream; i_data bit 15 set is treated as zero;
//   i_last/o_ready     o_ready is high only while collecting a row
//   o_valid/o_data/    normalized output stream (Q6.10); o_last marks the row's last element
//   o_last/i_ready
//   o_ovf              one-cycle pulse when a row is cut off at MAX_LEN elements
module softmax_normalizer #(
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned ACC_W   = 24
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [15:0] i_data,
  input  logic        i_last,
  output logic        o_ready,
  output logic        o_valid,
  output logic [15:0] o_data,
  output logic        o_last,
  input  logic        i_ready,
  output logic        o_ovf
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0]    LastIdx   = CW'(MAX_LEN - 1);
  localparam logic [ACC_W-1:0] SumSatThr = ACC_W'(16'h7FFF);

  typedef enum logic [1:0] {StAccum, StRecip, StNorm} state_e;

  // Q6.10 reciprocal: 2^20 / s, clamped to the largest positive Q6.10 value.
  function automatic logic [15:0] reciprocal(input logic [15:0] s);
    logic [20:0] q;
    q = 21'h10_0000 / {5'd0, s};
    return (q > 21'h00_7FFF) ? 16'h7FFF : q[15:0];
  endfunction

  state_e           state_q;
  logic [CW-1:0]    cnt_q, len_q, rd_ptr_q;
  logic [ACC_W-1:0] acc_q, acc_next;
  logic [ACC_W:0]   acc_sum;
  logic [15:0]      recip_q, recip_new, recip_use, sat_sum;
  logic [15:0]      in_data, rd_data, norm_data;
  logic [31:0]      prod, prod_shr;
  logic [AW-1:0]    rd_idx;
  logic             accept, norm_load;
  logic             valid_q, last_q, ovf_q;
  logic [15:0]      data_q;

  // Row buffer; no reset, every entry is written before it is read.
  logic [15:0] row_mem [MAX_LEN];

  always_comb begin
    in_data   = i_data[15] ? 16'h0000 : i_data;
    accept    = i_valid && (state_q == StAccum);
    acc_sum   = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, in_data};
    acc_next  = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    sat_sum   = (acc_q > SumSatThr) ? 16'h7FFF : acc_q[15:0];
    recip_new = (sat_sum == 16'h0000) ? 16'h7FFF : reciprocal(sat_sum);
    // Element 0 is loaded in the StRecip cycle with the reciprocal that is being registered,
    // so the first output appears two cycles after the last input is accepted.
    recip_use = (state_q == StRecip) ? recip_new : recip_q;
    rd_idx    = (state_q == StRecip) ? '0 : rd_ptr_q[AW-1:0];
    rd_data   = row_mem[rd_idx];
    prod      = {16'h0000, rd_data} * {16'h0000, recip_use};
`ifdef SOFTMAX_NORM_ROUND_EN
    prod_shr  = (prod + 32'h0000_0200) >> 10;
`else
    prod_shr  = prod >> 10;
`endif
    norm_data = (prod_shr > 32'h0000_7FFF) ? 16'h7FFF : prod_shr[15:0];
    norm_load = (state_q == StNorm) && (!valid_q || i_ready) && (rd_ptr_q < len_q);
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      row_mem[cnt_q[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StAccum;
      cnt_q    <= '0;
      len_q    <= '0;
      rd_ptr_q <= '0;
      acc_q    <= '0;
      recip_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      unique case (state_q)
        StAccum: begin
          if (accept) begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + CW'(1);
            if (i_last || (cnt_q == LastIdx)) begin
              state_q <= StRecip;
            end
            if (!i_last && (cnt_q == LastIdx)) begin
              ovf_q <= 1'b1;
            end
          end
        end
        StRecip: begin
          recip_q  <= recip_new;
          len_q    <= cnt_q;
          cnt_q    <= '0;
          acc_q    <= '0;
          valid_q  <= 1'b1;
          data_q   <= norm_data;
          last_q   <= (cnt_q == CW'(1));
          rd_ptr_q <= CW'(1);
          state_q  <= StNorm;
        end
        StNorm: begin
          if (norm_load) begin
            valid_q  <= 1'b1;
            data_q   <= norm_data;
            last_q   <= (rd_ptr_q == (len_q - CW'(1)));
            rd_ptr_q <= rd_ptr_q + CW'(1);
          end else if (valid_q && i_ready) begin
            // Last element handed off: row complete.
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            rd_ptr_q <= '0;
            state_q  <= StAccum;
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

  assign o_ready = (state_q == StAccum);
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_softmax_normalizer.sv
module tb_softmax_normalizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_valid = 1'b0;
  logic [15:0] i_data = 16'h0000;
  logic        i_last = 1'b0;
  logic        i_ready = 1'b1;
  logic        o_ready, o_valid, o_last, o_ovf;
  logic [15:0] o_data;

  int checks = 0;
  int errors = 0;
  int ovf_seen = 0;

  logic [15:0] cap_data [0:127];
  logic        cap_last [0:127];

  softmax_normalizer #(.MAX_LEN(64), .ACC_W(24)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_last  (i_last),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_last  (o_last),
    .i_ready (i_ready),
    .o_ovf   (o_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Drives n copies of d; i_last on the final one when last_on_final. Waits for o_ready.
  task automatic send(input int n, input logic [15:0] d, input logic last_on_final,
                      output logic ok);
    int budget;
    logic acc;
    ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      i_valid = 1'b1;
      i_data  = d;
      i_last  = last_on_final && (k == n - 1);
      budget  = 50;
      do begin
        acc = o_ready;
        @(posedge clk);
        #1;
        if (o_ovf === 1'b1) ovf_seen++;
        budget--;
      end while (!acc && budget > 0);
      if (!acc) ok = 1'b0;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_data  = 16'h0000;
  endtask

  // Captures n output transfers (i_ready held high), then lets the final handshake complete.
  task automatic collect(input int n, output int got);
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (o_valid === 1'b1 && i_ready) begin
        cap_data[got] = o_data;
        cap_last[got] = o_last;
        got++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if ({o_ready, o_valid, o_last, o_ovf} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 1000", {o_ready, o_valid, o_last, o_ovf});
    end
    checks++;
    if (o_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: got %h want 0000", o_data);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_row();
    logic ok;
    int got;
    send(4, 16'h0100, 1'b1, ok);
    collect(4, got);
    checks++;
    if (ok !== 1'b1 || got !== 4) begin
      errors++;
      $display("FAIL basic_count: got accept=%b outputs=%0d want 1/4", ok, got);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_data[i] !== 16'h0100 || cap_last[i] !== (i == 3)) begin
        errors++;
        $display("FAIL basic_out[%0d]: got %h/%b want 0100/%b", i, cap_data[i], cap_last[i],
                 (i == 3));
      end
    end
    checks++;
    if (dut.recip_q !== 16'h0400) begin
      errors++;
      $display("FAIL basic_recip: got %h want 0400", dut.recip_q);
    end
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle: got valid=%b ready=%b want 0/1", o_valid, o_ready);
    end
  endtask

  task automatic test_latency_single();
    logic ok;
    send(1, 16'h0400, 1'b1, ok);
    checks++;
    if (ok !== 1'b1 || o_valid !== 1'b0 || o_ready !== 1'b0) begin
      errors++;
      $display("FAIL lat_recip_cycle: got ok=%b valid=%b ready=%b want 1/0/0", ok, o_valid,
               o_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_data !== 16'h0400 || o_last !== 1'b1) begin
      errors++;
      $display("FAIL lat_first_out: got %b/%h/%b want 1/0400/1", o_valid, o_data, o_last);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL lat_done: got valid=%b ready=%b want 0/1", o_valid, o_ready);
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    int got, cyc;
    logic stalled;
    send(4, 16'h0100, 1'b1, ok);
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    while (got < 4 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (o_valid === 1'b1) begin
        if (got == 1 && !stalled) begin
          stalled = 1'b1;
          i_ready = 1'b0;
          repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (o_valid !== 1'b1 || o_data !== 16'h0100 || o_last !== 1'b0) begin
              errors++;
              $display("FAIL bp_hold: got %b/%h/%b want 1/0100/0", o_valid, o_data, o_last);
            end
          end
          i_ready = 1'b1;
        end
        cap_data[got] = o_data;
        cap_last[got] = o_last;
        got++;
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (got !== 4 || !stalled) begin
      errors++;
      $display("FAIL bp_count: got %0d outputs stalled=%b want 4/1", got, stalled);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_data[i] !== 16'h0100 || cap_last[i] !== (i == 3)) begin
        errors++;
        $display("FAIL bp_out[%0d]: got %h/%b want 0100/%b", i, cap_data[i], cap_last[i],
                 (i == 3));
      end
    end
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_idle: got valid=%b ready=%b want 0/1", o_valid, o_ready);
    end
  endtask

  task automatic test_inexact_row();
    logic ok;
    int got;
    // sum 0x0300 -> recip floor(2^20/768)=0x0555; 0x0100*0x0555>>10 = 0x0155
    send(3, 16'h0100, 1'b1, ok);
    collect(3, got);
    checks++;
    if (got !== 3 || dut.recip_q !== 16'h0555) begin
      errors++;
      $display("FAIL inexact_recip: got n=%0d recip=%h want 3/0555", got, dut.recip_q);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cap_data[i] !== 16'h0155 || cap_last[i] !== (i == 2)) begin
        errors++;
        $display("FAIL inexact_out[%0d]: got %h/%b want 0155/%b", i, cap_data[i], cap_last[i],
                 (i == 2));
      end
    end
  endtask

  task automatic test_sum_saturation();
    logic ok;
    int got;
    // sum 0xFFFE clamps to 0x7FFF -> recip 0x0020; 0x7FFF*0x20>>10 = 0x03FF
    send(2, 16'h7FFF, 1'b1, ok);
    collect(2, got);
    checks++;
    if (got !== 2 || dut.recip_q !== 16'h0020) begin
      errors++;
      $display("FAIL sat_recip: got n=%0d recip=%h want 2/0020", got, dut.recip_q);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (cap_data[i] !== 16'h03FF || cap_last[i] !== (i == 1)) begin
        errors++;
        $display("FAIL sat_out[%0d]: got %h/%b want 03FF/%b", i, cap_data[i], cap_last[i],
                 (i == 1));
      end
    end
  endtask

  task automatic test_overflow();
    logic ok;
    int got, bad;
    ovf_seen = 0;
    send(64, 16'h0010, 1'b0, ok);
    checks++;
    if (ok !== 1'b1 || ovf_seen !== 1) begin
      errors++;
      $display("FAIL ovf_pulse: got accept=%b pulses=%0d want 1/1", ok, ovf_seen);
    end
    collect(64, got);
    checks++;
    if (got !== 64) begin
      errors++;
      $display("FAIL ovf_count: got %0d outputs want 64", got);
    end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (cap_data[i] !== 16'h0010 || cap_last[i] !== (i == 63)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL ovf_out: got %0d bad elements (last=%h/%b) want 0 (0010/1)", bad,
               cap_data[63], cap_last[63]);
    end
    send(1, 16'h0200, 1'b0, ok);
    send(1, 16'h0200, 1'b1, ok);
    collect(2, got);
    checks++;
    if (got !== 2 || cap_data[0] !== 16'h0200 || cap_data[1] !== 16'h0200 ||
        cap_last[0] !== 1'b0 || cap_last[1] !== 1'b1 || ovf_seen !== 1) begin
      errors++;
      $display("FAIL ovf_next_row: got n=%0d %h/%b %h/%b pulses=%0d want 2 0200/0 0200/1 1",
               got, cap_data[0], cap_last[0], cap_data[1], cap_last[1], ovf_seen);
    end
  endtask

  task automatic test_negative();
    logic ok;
    int got;
    send(3, 16'hFC00, 1'b1, ok);
    collect(3, got);
    checks++;
    if (got !== 3 || dut.recip_q !== 16'h7FFF) begin
      errors++;
      $display("FAIL neg_recip: got n=%0d recip=%h want 3/7FFF", got, dut.recip_q);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cap_data[i] !== 16'h0000 || cap_last[i] !== (i == 2)) begin
        errors++;
        $display("FAIL neg_out[%0d]: got %h/%b want 0000/%b", i, cap_data[i], cap_last[i],
                 (i == 2));
      end
    end
  endtask

  task automatic test_reset_mid_norm();
    logic ok;
    int got;
    i_ready = 1'b0;
    send(4, 16'h0100, 1'b1, ok);
    @(posedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre: got valid=%b ready=%b want 1/0", o_valid, o_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_ready, o_valid, o_last, o_ovf} !== 4'b1000 || o_data !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid: got flags=%b data=%h want 1000/0000",
               {o_ready, o_valid, o_last, o_ovf}, o_data);
    end
    @(negedge clk) rst_n = 1'b1;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    send(2, 16'h0200, 1'b1, ok);
    collect(2, got);
    checks++;
    if (got !== 2 || cap_data[0] !== 16'h0200 || cap_data[1] !== 16'h0200 ||
        cap_last[0] !== 1'b0 || cap_last[1] !== 1'b1) begin
      errors++;
      $display("FAIL rst_next_row: got n=%0d %h/%b %h/%b want 2 0200/0 0200/1", got,
               cap_data[0], cap_last[0], cap_data[1], cap_last[1]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_row();
    test_latency_single();
    test_backpressure();
    test_inexact_row();
    test_sum_saturation();
    test_overflow();
    test_negative();
    test_reset_mid_norm();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
